// File: rtl/ucsbece154b_bpred_ras_if.sv
// Fetch/execute-facing bundle of the gshare + BTB + RAS branch predictor.
// The predictor takes the slave side; the pipeline (or a bench) takes the master side.
interface ucsbece154b_bpred_ras_if #(
  parameter int NUM_GHR_BITS    = 5,
  parameter int NUM_PHT_ENTRIES = 64,
  parameter int RAS_DEPTH       = 8
);
  localparam int PW = $clog2(NUM_PHT_ENTRIES);
  localparam int RW = $clog2(RAS_DEPTH);

  logic [31:0]             pc_i;
  logic                    fetch_valid_i;
  logic                    predict_taken_o;
  logic [31:0]             predict_target_o;
  logic [1:0]              predict_type_o;
  logic                    predict_hit_o;
  logic [PW-1:0]           pht_index_o;
  logic [NUM_GHR_BITS-1:0] ghr_ckpt_o;
  logic [2*RW:0]           ras_ckpt_o;
  logic                    resolve_valid_i;
  logic [31:0]             resolve_pc_i;
  logic [1:0]              resolve_type_i;
  logic                    resolve_taken_i;
  logic [31:0]             resolve_target_i;
  logic [PW-1:0]           resolve_pht_index_i;
  logic [NUM_GHR_BITS-1:0] resolve_ghr_i;
  logic [2*RW:0]           resolve_ras_i;
  logic                    resolve_mispredict_i;

  modport master (
    output pc_i, fetch_valid_i, resolve_valid_i, resolve_pc_i, resolve_type_i,
           resolve_taken_i, resolve_target_i, resolve_pht_index_i, resolve_ghr_i,
           resolve_ras_i, resolve_mispredict_i,
    input  predict_taken_o, predict_target_o, predict_type_o, predict_hit_o,
           pht_index_o, ghr_ckpt_o, ras_ckpt_o
  );

  modport slave (
    input  pc_i, fetch_valid_i, resolve_valid_i, resolve_pc_i, resolve_type_i,
           resolve_taken_i, resolve_target_i, resolve_pht_index_i, resolve_ghr_i,
           resolve_ras_i, resolve_mispredict_i,
    output predict_taken_o, predict_target_o, predict_type_o, predict_hit_o,
           pht_index_o, ghr_ckpt_o, ras_ckpt_o
  );
endinterface

// File: rtl/ucsbece154b_bpred_ras.sv
// Gshare direction predictor with a direct-mapped tagged BTB and a circular return-address stack.
// Same-cycle lookup at fetch; training and checkpoint-based history repair at execute.
module ucsbece154b_bpred_ras #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5,
  parameter int NUM_PHT_ENTRIES = 64,
  parameter int RAS_DEPTH       = 8
) (
  input logic                    clk,
  input logic                    reset_ni,
  ucsbece154b_bpred_ras_if.slave bp
);
  localparam int IDX = $clog2(NUM_BTB_ENTRIES);
  localparam int TW  = 30 - IDX;
  localparam int PW  = $clog2(NUM_PHT_ENTRIES);
  localparam int RW  = $clog2(RAS_DEPTH);

  localparam logic [1:0]  T_BRANCH = 2'b00;
  localparam logic [1:0]  T_CALL   = 2'b10;
  localparam logic [1:0]  T_RET    = 2'b11;
  localparam logic [RW:0] CNT_FULL = (RW+1)'(RAS_DEPTH);
  localparam logic [RW:0] CNT_ZERO = {(RW+1){1'b0}};

  logic [NUM_BTB_ENTRIES-1:0] btb_valid_r;
  logic [TW-1:0]              btb_tag_r    [NUM_BTB_ENTRIES];
  logic [31:0]                btb_target_r [NUM_BTB_ENTRIES];
  logic [1:0]                 btb_type_r   [NUM_BTB_ENTRIES];
  logic [1:0]                 pht_r        [NUM_PHT_ENTRIES];
  logic [NUM_GHR_BITS-1:0]    ghr_r;
  logic [31:0]                ras_data_r   [RAS_DEPTH];
  logic [RW-1:0]              ras_ptr_r;
  logic [RW:0]                ras_cnt_r;

  logic [IDX-1:0]          f_idx_s;
  logic [IDX-1:0]          r_idx_s;
  logic                    hit_s;
  logic [PW-1:0]           pht_idx_s;
  logic                    pred_taken_s;
  logic [31:0]             pred_target_s;
  logic [1:0]              pred_type_s;
  logic                    repair_s;
  logic [NUM_GHR_BITS-1:0] ghr_nxt_s;
  logic [RW-1:0]           ras_ptr_base_s;
  logic [RW:0]             ras_cnt_base_s;
  logic                    ras_push_s;
  logic                    ras_pop_s;
  logic [31:0]             ras_push_data_s;
  logic [RW-1:0]           ras_ptr_nxt_s;
  logic [RW:0]             ras_cnt_nxt_s;

  assign f_idx_s  = bp.pc_i[IDX+1:2];
  assign r_idx_s  = bp.resolve_pc_i[IDX+1:2];
  assign repair_s = bp.resolve_valid_i && bp.resolve_mispredict_i;

  // Fetch-side lookup: BTB hit, gshare direction and target selection
  always_comb begin
    hit_s         = btb_valid_r[f_idx_s] && (btb_tag_r[f_idx_s] == bp.pc_i[31:IDX+2]);
    pht_idx_s     = bp.pc_i[PW+1:2] ^ PW'(ghr_r);
    pred_taken_s  = 1'b0;
    pred_target_s = 32'd0;
    pred_type_s   = T_BRANCH;
    if (hit_s) begin
      pred_type_s   = btb_type_r[f_idx_s];
      pred_target_s = btb_target_r[f_idx_s];
      case (btb_type_r[f_idx_s])
        T_BRANCH: pred_taken_s = pht_r[pht_idx_s][1];
        T_RET: begin
          pred_taken_s = 1'b1;
          if (ras_cnt_r != CNT_ZERO) begin
            pred_target_s = ras_data_r[ras_ptr_r];
          end else begin
            pred_target_s = btb_target_r[f_idx_s];
          end
        end
        default: pred_taken_s = 1'b1;
      endcase
    end else begin
      pred_taken_s = 1'b0;
    end
  end

  assign bp.predict_hit_o    = hit_s;
  assign bp.predict_taken_o  = pred_taken_s;
  assign bp.predict_target_o = pred_target_s;
  assign bp.predict_type_o   = pred_type_s;
  assign bp.pht_index_o      = pht_idx_s;
  assign bp.ghr_ckpt_o       = ghr_r;
  assign bp.ras_ckpt_o       = {ras_cnt_r, ras_ptr_r};

  // History source select: a repair rebuilds from the checkpoint and masks fetch speculation
  always_comb begin
    ghr_nxt_s       = ghr_r;
    ras_ptr_base_s  = ras_ptr_r;
    ras_cnt_base_s  = ras_cnt_r;
    ras_push_s      = 1'b0;
    ras_pop_s       = 1'b0;
    ras_push_data_s = bp.pc_i + 32'd4;
    if (repair_s) begin
      if (bp.resolve_type_i == T_BRANCH) begin
        ghr_nxt_s = {bp.resolve_ghr_i[NUM_GHR_BITS-2:0], bp.resolve_taken_i};
      end else begin
        ghr_nxt_s = bp.resolve_ghr_i;
      end
      ras_cnt_base_s  = bp.resolve_ras_i[2*RW:RW];
      ras_ptr_base_s  = bp.resolve_ras_i[RW-1:0];
      ras_push_s      = (bp.resolve_type_i == T_CALL);
      ras_pop_s       = (bp.resolve_type_i == T_RET);
      ras_push_data_s = bp.resolve_pc_i + 32'd4;
    end else if (bp.fetch_valid_i && hit_s) begin
      case (btb_type_r[f_idx_s])
        T_BRANCH: ghr_nxt_s  = {ghr_r[NUM_GHR_BITS-2:0], pred_taken_s};
        T_CALL:   ras_push_s = 1'b1;
        T_RET:    ras_pop_s  = 1'b1;
        default:  ghr_nxt_s  = ghr_r;
      endcase
    end else begin
      ghr_nxt_s = ghr_r;
    end
  end

  // RAS pointer/count arithmetic; a full stack keeps its count and overwrites the oldest slot
  always_comb begin
    ras_ptr_nxt_s = ras_ptr_base_s;
    ras_cnt_nxt_s = ras_cnt_base_s;
    if (ras_push_s) begin
      ras_ptr_nxt_s = ras_ptr_base_s + RW'(1);
      if (ras_cnt_base_s != CNT_FULL) begin
        ras_cnt_nxt_s = ras_cnt_base_s + (RW+1)'(1);
      end else begin
        ras_cnt_nxt_s = ras_cnt_base_s;
      end
    end else if (ras_pop_s && (ras_cnt_base_s != CNT_ZERO)) begin
      ras_ptr_nxt_s = ras_ptr_base_s - RW'(1);
      ras_cnt_nxt_s = ras_cnt_base_s - (RW+1)'(1);
    end else begin
      ras_ptr_nxt_s = ras_ptr_base_s;
    end
  end

  // Speculative history registers
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      ghr_r     <= {NUM_GHR_BITS{1'b0}};
      ras_ptr_r <= {RW{1'b0}};
      ras_cnt_r <= CNT_ZERO;
    end else begin
      ghr_r     <= ghr_nxt_s;
      ras_ptr_r <= ras_ptr_nxt_s;
      ras_cnt_r <= ras_cnt_nxt_s;
    end
  end

  // RAS storage (contents are never restored on repair)
  always_ff @(posedge clk) begin
    if (ras_push_s) begin
      ras_data_r[ras_ptr_nxt_s] <= ras_push_data_s;
    end
  end

  // BTB valid bits: only taken resolutions allocate
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      btb_valid_r <= {NUM_BTB_ENTRIES{1'b0}};
    end else if (bp.resolve_valid_i && bp.resolve_taken_i) begin
      btb_valid_r[r_idx_s] <= 1'b1;
    end
  end

  // BTB payload
  always_ff @(posedge clk) begin
    if (bp.resolve_valid_i && bp.resolve_taken_i) begin
      btb_tag_r[r_idx_s]    <= bp.resolve_pc_i[31:IDX+2];
      btb_target_r[r_idx_s] <= bp.resolve_target_i;
      btb_type_r[r_idx_s]   <= bp.resolve_type_i;
    end
  end

  // PHT saturating counters, trained with the index captured at fetch
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_PHT_ENTRIES; i++) begin
        pht_r[i] <= 2'b01;
      end
    end else if (bp.resolve_valid_i && (bp.resolve_type_i == T_BRANCH)) begin
      if (bp.resolve_taken_i && (pht_r[bp.resolve_pht_index_i] != 2'b11)) begin
        pht_r[bp.resolve_pht_index_i] <= pht_r[bp.resolve_pht_index_i] + 2'b01;
      end else if (!bp.resolve_taken_i && (pht_r[bp.resolve_pht_index_i] != 2'b00)) begin
        pht_r[bp.resolve_pht_index_i] <= pht_r[bp.resolve_pht_index_i] - 2'b01;
      end
    end
  end
endmodule
